icache: RTL and testbench
=========================

# icache

Direct-mapped instruction cache between the instruction unit's fetch port (`pc`, `inst_req`) and the memory unit's byte-wide read path. It returns a 32-bit instruction one cycle after a hit and refills a whole line on a miss. During a refill it streams bytes from the memory unit in address order, then answers the pending fetch. A pipeline `clear` suppresses any response still in flight.

## Interface
- `LINE_BIT`, 4: log2 of line size in bytes (16-byte lines).
- `INDEX_BIT`, 6: log2 of line count (64 lines, 1 KiB).
- `clk_in` in 1: clock.
- `rst_in` in 1: reset, synchronous, active-low.
- `rdy_in` in 1: global ready; when low, all state holds.
- `clear` in 1: pipeline flush from the ROB.
- `inst_req` in 1: fetch request from the instruction unit.
- `pc_in` in 32: fetch address; `pc_in[1:0]` is ignored.
- `inst_ready` out 1: `inst` is valid this cycle.
- `inst` out 32: fetched instruction word, little-endian.
- `fill_req` out 1: line refill request to the memory unit.
- `fill_addr` out 32: line base address, `{tag,index,LINE_BIT'b0}`.
- `fill_valid` in 1: one refill byte is present on `fill_data`.
- `fill_data` in 8: refill byte; bytes arrive strictly in ascending offset order.

## Operation
- Address split:
  - offset = `pc[LINE_BIT-1:0]`
  - index = `pc[LINE_BIT+INDEX_BIT-1:LINE_BIT]`
  - tag = `pc[31:LINE_BIT+INDEX_BIT]`
- Storage: `valid[2^INDEX_BIT]`, `tag[]`, `data[]` of `8<<LINE_BIT` bits per line.
- States:
  - IDLE: lookup on `inst_req`. On hit, register the word for `pc[LINE_BIT-1:2]` and stay in IDLE. On miss, latch `pc` and go to FILL.
  - FILL: `fill_req` is held at 1. Each `fill_valid` stores `fill_data` at byte `cnt` and increments `cnt`. When `cnt` wraps (byte `2^LINE_BIT - 1` accepted), write the line with valid=1 and the latched tag, then go to RESP.
  - RESP: drive `inst_ready` with the word from the just-written line, then return to IDLE.
- `inst_req` is ignored outside IDLE. The instruction unit holds `pc` stable until `inst_ready`.
- `clear`:
  - In IDLE: no response next cycle, and that cycle's `inst_req` is ignored.
  - In FILL: the fill completes and the line is written; the block then goes to IDLE with no response.
  - In RESP: go to IDLE with `inst_ready` = 0.
- `rdy_in` low: every register, including the outputs, holds its value. `fill_valid` is not accepted.
- Reset: all valid bits are cleared and state goes to IDLE. `inst_ready`, `fill_req`, `cnt` are 0; `inst` and `fill_addr` are 0.

## Timing
- Hit: `inst_req` at edge t → `inst_ready`=1 for exactly one cycle after t.
- Miss: `inst_req` at t → `fill_req`=1 from t+1. After the 16th `fill_valid` at edge f, the line is written at f+1 and `inst_ready`=1 in cycle f+1 → f+2.
- Minimum miss latency with back-to-back bytes is 2^LINE_BIT + 2 cycles.
- `fill_req` drops in the cycle after the last byte is accepted.
- `fill_valid` with `fill_req`=0 is ignored.
- Back-to-back hits sustain one `inst_ready` per cycle.
- Reset in mid-fill takes priority over everything: partial data is discarded and the line is not marked valid.
- `clear` and the final `fill_valid` in the same cycle: the line is written and no response is given.

## Structure
- `const.v` holds `ICACHE_LINE_BIT`, `ICACHE_INDEX_BIT` and the state encodings (IDLE=0, FILL=1, RESP=2).
- One sub-module, `icache_fill_buffer`, holds the byte counter and line assembly register. Its outputs are `done` and `line`.

## Test plan
- Cold miss at `pc`=0x0000_0000, memory bytes 0x00..0x0F → `fill_addr`=0x0, 16 bytes consumed, `inst`=0x0302_0100, `inst_ready` 18 cycles after the request.
- Hit after that fill at `pc`=0x0000_000C → `inst`=0x0F0E_0D0C one cycle later. `fill_req` stays 0.
- Conflict at `pc`=0x0000_0400 (same index, new tag) → refill, new word returned. A re-fetch of 0x0 then misses again.
- `clear` raised in the 5th FILL cycle → fill completes, no `inst_ready`, state is IDLE. A re-fetch of the same pc hits in 1 cycle.
- `rdy_in` low for 3 cycles mid-fill with `fill_valid` toggling → `cnt` frozen. Data is correct after resume.
- `rst_in`=0 on the 8th fill byte → `fill_req`=0 next cycle. A re-fetch of the same pc misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ICACHE_LINE_BIT  = 4;
  localparam int ICACHE_INDEX_BIT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/icache_fill_buffer.sv
// Assembles one cache line from the byte-wide refill stream, lowest offset first.
import icache_pkg::*;

module icache_fill_buffer #(
  parameter int LINE_BIT = ICACHE_LINE_BIT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      accept,
  input  logic [7:0]                fill_data,
  output logic                      last,
  output logic                      done,
  output logic [(8<<LINE_BIT)-1:0]  line
);

  logic [LINE_BIT-1:0]       cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic [(8<<LINE_BIT)-1:0]  line_q, line_d;

  // The counter wraps back to zero on the final byte, so the next fill starts clean.
  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    last   = accept && (cnt_q == '1);
    done_d = last;
    if (accept) begin
      line_d[{cnt_q, 3'b000} +: 8] = fill_data;
      cnt_d                        = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      line_q <= '0;
    end else if (rdy_in) begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      line_q <= line_d;
    end
  end

  assign done = done_q;
  assign line = line_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: one-cycle hits, whole-line refill on a miss,
// with clear suppressing any response still in flight.
import icache_pkg::*;

module icache #(
  parameter int LINE_BIT  = ICACHE_LINE_BIT,
  parameter int INDEX_BIT = ICACHE_INDEX_BIT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        inst_req,
  input  logic [31:0] pc_in,
  output logic        inst_ready,
  output logic [31:0] inst,
  output logic        fill_req,
  output logic [31:0] fill_addr,
  input  logic        fill_valid,
  input  logic [7:0]  fill_data
);

  localparam int TAG_BIT  = 32 - LINE_BIT - INDEX_BIT;
  localparam int LINES    = 1 << INDEX_BIT;
  localparam int LINE_W   = 8 << LINE_BIT;
  localparam int WORD_BIT = LINE_BIT - 2;

  state_e               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          inst_q, inst_d;
  logic [31:0]          fill_addr_q, fill_addr_d;
  logic                 inst_ready_q, inst_ready_d;
  logic                 fill_req_q, fill_req_d;
  logic                 kill_q, kill_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [TAG_BIT-1:0]   tag_q  [LINES];
  logic [LINE_W-1:0]    data_q [LINES];

  logic [INDEX_BIT-1:0] req_index, fill_index;
  logic [TAG_BIT-1:0]   req_tag, fill_tag;
  logic [WORD_BIT-1:0]  req_word, fill_word;
  logic [LINE_W-1:0]    hit_line, fill_line;
  logic                 hit, fill_accept, fill_last, fill_done, line_we;
  logic                 pc_unused;

  assign req_index   = pc_in[LINE_BIT +: INDEX_BIT];
  assign req_tag     = pc_in[31 -: TAG_BIT];
  assign req_word    = pc_in[2 +: WORD_BIT];
  assign fill_index  = pc_q[LINE_BIT +: INDEX_BIT];
  assign fill_tag    = pc_q[31 -: TAG_BIT];
  assign fill_word   = pc_q[2 +: WORD_BIT];
  assign pc_unused   = ^{pc_in[1:0], pc_q[1:0]};

  assign hit_line    = data_q[req_index];
  assign hit         = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign fill_accept = fill_valid && fill_req_q;

  icache_fill_buffer #(.LINE_BIT(LINE_BIT)) u_fill_buffer (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .accept    (fill_accept),
    .fill_data (fill_data),
    .last      (fill_last),
    .done      (fill_done),
    .line      (fill_line)
  );

  // A clear seen at any point of a fill is remembered in kill so the line still lands silently.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_ready_d = 1'b0;
    fill_req_d   = fill_req_q;
    fill_addr_d  = fill_addr_q;
    kill_d       = kill_q;
    valid_d      = valid_q;
    line_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_req && !clear) begin
          if (hit) begin
            inst_d       = hit_line[{req_word, 5'b00000} +: 32];
            inst_ready_d = 1'b1;
          end else begin
            pc_d        = pc_in;
            fill_addr_d = {pc_in[31:LINE_BIT], {LINE_BIT{1'b0}}};
            fill_req_d  = 1'b1;
            kill_d      = 1'b0;
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        if (clear) kill_d = 1'b1;
        if (fill_last) fill_req_d = 1'b0;
        if (fill_done) begin
          line_we             = 1'b1;
          valid_d[fill_index] = 1'b1;
          if (kill_q || clear) begin
            state_d = IDLE;
          end else begin
            inst_d       = fill_line[{fill_word, 5'b00000} +: 32];
            inst_ready_d = 1'b1;
            state_d      = RESP;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      inst_q       <= '0;
      inst_ready_q <= 1'b0;
      fill_req_q   <= 1'b0;
      fill_addr_q  <= '0;
      kill_q       <= 1'b0;
      valid_q      <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_ready_q <= inst_ready_d;
      fill_req_q   <= fill_req_d;
      fill_addr_q  <= fill_addr_d;
      kill_q       <= kill_d;
      valid_q      <= valid_d;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && line_we) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_line;
    end
  end

  assign inst_ready = inst_ready_q;
  assign inst       = inst_q;
  assign fill_req   = fill_req_q;
  assign fill_addr  = fill_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed scoreboard bench for icache: fetches push expected words, a negedge monitor pops them.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] pc_in = '0;
  logic        fill_valid = 1'b0;
  logic [7:0]  fill_data = '0;
  logic        inst_ready;
  logic [31:0] inst;
  logic        fill_req;
  logic [31:0] fill_addr;

  int          checks = 0;
  int          errors = 0;
  int          exp_count = 0;
  int          resp_count = 0;
  int          cycle = 0;
  int          req_cycle = 0;
  int          last_ready_cycle = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  icache dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .inst_req   (inst_req),
    .pc_in      (pc_in),
    .inst_ready (inst_ready),
    .inst       (inst),
    .fill_req   (fill_req),
    .fill_addr  (fill_addr),
    .fill_valid (fill_valid),
    .fill_data  (fill_data)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Any response must match the oldest outstanding expectation; unexpected ones are errors.
  always @(negedge clk_in) begin
    if (inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_inst_ready: actual inst=%h required no response", inst);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("inst", inst, mon_exp);
        resp_count++;
        last_ready_cycle = cycle;
      end
    end
  end

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[17:10];
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] exp_word, input bit expect_resp);
    if (expect_resp) begin
      exp_q.push_back(exp_word);
      exp_count++;
    end
    inst_req  = 1'b1;
    pc_in     = pc;
    req_cycle = cycle;
    step();
    inst_req  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (resp_count != exp_count && n < budget) begin
      step();
      n++;
    end
    if (resp_count != exp_count) begin
      checks++;
      errors++;
      $display("[TB] FAIL response_timeout: actual responses=%0d required=%0d", resp_count, exp_count);
      exp_q.delete();
      resp_count = exp_count;
    end
  endtask

  // One miss: request, 16 bytes in order, optional clear / rdy gap / reset at a given byte.
  task automatic miss_fill(input logic [31:0] pc, input logic [31:0] exp_word, input bit expect_resp,
                           input int clear_at, input int gap_at, input int rst_at);
    logic [31:0] base;
    base = {pc[31:4], 4'h0};
    applyStimulus(pc, exp_word, expect_resp);
    checkOutput("fill_req_start", {31'b0, fill_req}, 32'd1);
    checkOutput("fill_addr", fill_addr, base);
    for (int i = 0; i < 16; i++) begin
      if (i == rst_at) begin
        rst_in     = 1'b0;
        fill_valid = 1'b1;
        fill_data  = mem_byte(base + i);
        step();
        rst_in     = 1'b1;
        fill_valid = 1'b0;
        checkOutput("fill_req_after_reset", {31'b0, fill_req}, 32'd0);
        checkOutput("inst_ready_after_reset", {31'b0, inst_ready}, 32'd0);
        return;
      end
      if (i == gap_at) begin
        rdy_in = 1'b0;
        for (int g = 0; g < 3; g++) begin
          fill_valid = (g != 1);
          fill_data  = 8'hEE;
          step();
          checkOutput("fill_req_hold", {31'b0, fill_req}, 32'd1);
        end
        rdy_in = 1'b1;
      end
      fill_valid = 1'b1;
      fill_data  = mem_byte(base + i);
      clear      = (i == clear_at);
      step();
      clear      = 1'b0;
      if (i == 14) checkOutput("fill_req_before_last", {31'b0, fill_req}, 32'd1);
      if (i == 15) checkOutput("fill_req_after_last", {31'b0, fill_req}, 32'd0);
    end
    fill_valid = 1'b0;
    if (expect_resp) begin
      drain(8);
      checkOutput("miss_latency", last_ready_cycle - req_cycle, (gap_at >= 0) ? 32'd21 : 32'd18);
    end else begin
      repeat (3) step();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) step();
    checkOutput("reset_inst_ready", {31'b0, inst_ready}, 32'd0);
    checkOutput("reset_fill_req", {31'b0, fill_req}, 32'd0);
    checkOutput("reset_inst", inst, 32'd0);
    checkOutput("reset_fill_addr", fill_addr, 32'd0);
    rst_in = 1'b1;
    step();

    $display("[TB] cold miss at 0x0");
    miss_fill(32'h0000_0000, 32'h0302_0100, 1'b1, -1, -1, -1);

    $display("[TB] hits after fill");
    applyStimulus(32'h0000_000C, 32'h0F0E_0D0C, 1'b1);
    checkOutput("hit_inst_ready", {31'b0, inst_ready}, 32'd1);
    checkOutput("hit_fill_req", {31'b0, fill_req}, 32'd0);
    drain(4);
    applyStimulus(32'h0000_0004, 32'h0706_0504, 1'b1);
    applyStimulus(32'h0000_0008, 32'h0B0A_0908, 1'b1);
    checkOutput("b2b_inst_ready", {31'b0, inst_ready}, 32'd1);
    drain(4);

    $display("[TB] clear in IDLE drops the request");
    clear = 1'b1;
    applyStimulus(32'h0000_000C, 32'h0, 1'b0);
    clear = 1'b0;
    checkOutput("clear_idle_inst_ready", {31'b0, inst_ready}, 32'd0);
    step();

    $display("[TB] conflict miss and re-fetch");
    miss_fill(32'h0000_0400, 32'h0203_0001, 1'b1, -1, -1, -1);
    miss_fill(32'h0000_0000, 32'h0302_0100, 1'b1, -1, -1, -1);

    $display("[TB] stray fill_valid while idle");
    fill_valid = 1'b1;
    fill_data  = 8'hAA;
    repeat (2) step();
    fill_valid = 1'b0;
    checkOutput("stray_fill_req", {31'b0, fill_req}, 32'd0);

    $display("[TB] clear during fill");
    miss_fill(32'h0000_0010, 32'h0, 1'b0, 4, -1, -1);
    applyStimulus(32'h0000_0010, 32'h1312_1110, 1'b1);
    checkOutput("after_clear_hit", {31'b0, inst_ready}, 32'd1);
    checkOutput("after_clear_fill_req", {31'b0, fill_req}, 32'd0);
    drain(4);

    $display("[TB] clear with final byte");
    miss_fill(32'h0000_0058, 32'h0, 1'b0, 15, -1, -1);
    applyStimulus(32'h0000_0058, 32'h5B5A_5958, 1'b1);
    checkOutput("final_clear_hit", {31'b0, inst_ready}, 32'd1);
    drain(4);

    $display("[TB] rdy_in low mid-fill");
    miss_fill(32'h0000_0024, 32'h2726_2524, 1'b1, -1, 6, -1);
    applyStimulus(32'h0000_002C, 32'h2F2E_2D2C, 1'b1);
    checkOutput("gap_hit", {31'b0, inst_ready}, 32'd1);
    drain(4);

    $display("[TB] reset on 8th fill byte");
    miss_fill(32'h0000_0030, 32'h0, 1'b0, -1, -1, 7);
    step();
    miss_fill(32'h0000_0030, 32'h3332_3130, 1'b1, -1, -1, -1);
    miss_fill(32'h0000_0024, 32'h2726_2524, 1'b1, -1, -1, -1);

    repeat (3) step();
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
